// File: rtl/program_loader.sv
// program_loader: boot-stage loader for the pipelined MIPS core.
// Accepts a program image as a valid/ready byte stream, writes it word by word
// into the instruction memory, and holds the processor in reset until the
// image has loaded and its XOR checksum matches.
//
// Image layout: count_hi, count_lo (word count N, big-endian), N words of
// 4 bytes each (MSB first), then one checksum byte (XOR of the 4N payload bytes).
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 512,
    parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,          // asynchronous, active-low
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_address,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,      // active-low reset to the core
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT_HI,
        S_COUNT_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    state_e state_q, state_d;

    // Datapath registers
    logic [7:0]  count_hi_q,   count_hi_d;
    logic [15:0] word_count_q, word_count_d;
    logic [15:0] word_index_q, word_index_d;
    logic [1:0]  byte_index_q, byte_index_d;
    // Only the first three bytes of a word need storing: the fourth arrives
    // on the same cycle the word is committed to the write register.
    logic [23:0] shift_q,      shift_d;
    logic [7:0]  checksum_q,   checksum_d;

    // Registered outputs
    logic        imem_we_q,      imem_we_d;
    logic [31:0] imem_address_q, imem_address_d;
    logic [31:0] imem_wdata_q,   imem_wdata_d;
    logic        cpu_reset_q,    cpu_reset_d;
    logic        load_done_q,    load_done_d;
    logic        load_error_q,   load_error_d;

    logic        accept;
    logic [15:0] count_in;
    logic        last_byte_of_word;
    logic        last_word;

    assign accept            = byte_valid && byte_ready;
    assign count_in          = {count_hi_q, byte_in};
    assign last_byte_of_word = (byte_index_q == 2'd3);
    assign last_word         = ((word_index_q + 16'd1) == word_count_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (otherwise a latch would be inferred).
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COUNT_HI;
            end
            S_COUNT_HI: begin
                if (accept) state_d = S_COUNT_LO;
            end
            S_COUNT_LO: begin
                if (accept) begin
                    if (32'(count_in) > MEMORY_DEPTH) state_d = S_ERROR;
                    else if (count_in == 16'd0)       state_d = S_CHECK;
                    else                              state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && last_byte_of_word && last_word) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (accept) state_d = (byte_in == checksum_q) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) state_d = S_COUNT_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: byte_ready straight from the state register, the rest
    // as next values for the output registers so they track state_d.
    always_comb begin
        byte_ready   = (state_q == S_COUNT_HI) || (state_q == S_COUNT_LO) ||
                       (state_q == S_DATA)     || (state_q == S_CHECK);
        load_done_d  = (state_d == S_DONE);
        load_error_d = (state_d == S_ERROR);
        cpu_reset_d  = (state_d == S_DONE);
        imem_we_d    = (state_q == S_DATA) && accept && last_byte_of_word;
    end

    // Datapath next-state: count capture, byte assembly, checksum, write address
    always_comb begin
        count_hi_d     = count_hi_q;
        word_count_d   = word_count_q;
        word_index_d   = word_index_q;
        byte_index_d   = byte_index_q;
        shift_d        = shift_q;
        checksum_d     = checksum_q;
        imem_address_d = imem_address_q;
        imem_wdata_d   = imem_wdata_q;
        if (accept) begin
            unique case (state_q)
                S_COUNT_HI: begin
                    count_hi_d = byte_in;
                end
                S_COUNT_LO: begin
                    // Cleared for every count so an empty image checks against 0.
                    word_count_d = count_in;
                    word_index_d = 16'd0;
                    byte_index_d = 2'd0;
                    checksum_d   = 8'd0;
                end
                S_DATA: begin
                    shift_d      = {shift_q[15:0], byte_in};
                    checksum_d   = checksum_q ^ byte_in;
                    byte_index_d = byte_index_q + 2'd1;
                    if (last_byte_of_word) begin
                        imem_wdata_d   = {shift_q, byte_in};
                        imem_address_d = BASE_ADDRESS + {14'd0, word_index_q, 2'b00};
                        word_index_d   = word_index_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_hi_q     <= 8'd0;
            word_count_q   <= 16'd0;
            word_index_q   <= 16'd0;
            byte_index_q   <= 2'd0;
            shift_q        <= 24'd0;
            checksum_q     <= 8'd0;
            imem_we_q      <= 1'b0;
            imem_address_q <= 32'd0;
            imem_wdata_q   <= 32'd0;
            cpu_reset_q    <= 1'b0;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            count_hi_q     <= count_hi_d;
            word_count_q   <= word_count_d;
            word_index_q   <= word_index_d;
            byte_index_q   <= byte_index_d;
            shift_q        <= shift_d;
            checksum_q     <= checksum_d;
            imem_we_q      <= imem_we_d;
            imem_address_q <= imem_address_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_address = imem_address_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: hand-computed images, strobe
// latency, checksum pass/fail, oversize count, empty image, stream gaps and
// asynchronous mid-load reset.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_address;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int checks;
    int errors;
    int we_count;
    int we_base;

    program_loader #(
        .MEMORY_DEPTH (512),
        .BASE_ADDRESS (32'h0040_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_address (imem_address),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write strobes, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we === 1'b1) we_count++;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present one byte and return #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (byte_ready !== 1'b1) begin
            check("ready_timeout", {31'd0, byte_ready}, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
    endtask

    // Two-word image: 0x20080005, 0x01095020.
    // Payload XOR: 20^08^00^05^01^09^50^20 = 0x55.
    task automatic send_two_word_image(input logic [7:0] csum);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h01); send_byte(8'h09); send_byte(8'h50); send_byte(8'h20);
        send_byte(csum);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        we_count   = 0;
        reset      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_imem_we",    {31'd0, imem_we},    32'd0);
        check("rst_address",    imem_address,        32'd0);
        check("rst_wdata",      imem_wdata,          32'd0);
        check("rst_cpu_reset",  {31'd0, cpu_reset},  32'd0);
        check("rst_load_done",  {31'd0, load_done},  32'd0);
        check("rst_load_error", {31'd0, load_error}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_byte_ready", {31'd0, byte_ready}, 32'd0);

        // ---------------- two-word image, good checksum ----------------
        pulse_start();
        check("t1_ready_after_start", {31'd0, byte_ready}, 32'd1);
        we_base = we_count;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00);
        check("t1_no_we_mid_word", {31'd0, imem_we}, 32'd0);
        send_byte(8'h05);
        check("t1_w0_we",   {31'd0, imem_we}, 32'd1);
        check("t1_w0_addr", imem_address,     32'h0040_0000);
        check("t1_w0_data", imem_wdata,       32'h2008_0005);
        send_byte(8'h01);
        check("t1_we_one_cycle", {31'd0, imem_we}, 32'd0);
        send_byte(8'h09); send_byte(8'h50); send_byte(8'h20);
        check("t1_w1_we",   {31'd0, imem_we}, 32'd1);
        check("t1_w1_addr", imem_address,     32'h0040_0004);
        check("t1_w1_data", imem_wdata,       32'h0109_5020);
        check("t1_check_ready", {31'd0, byte_ready}, 32'd1);
        check("t1_cpu_held",    {31'd0, cpu_reset},  32'd0);
        send_byte(8'h55);
        check("t1_load_done",  {31'd0, load_done},  32'd1);
        check("t1_cpu_reset",  {31'd0, cpu_reset},  32'd1);
        check("t1_load_error", {31'd0, load_error}, 32'd0);
        check("t1_done_ready", {31'd0, byte_ready}, 32'd0);
        check("t1_we_count",   we_count - we_base,  32'd2);
        // Bytes offered in DONE must be ignored
        @(negedge clk);
        byte_in    = 8'hA5;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        check("t1_done_holds", {31'd0, load_done}, 32'd1);

        // ---------------- bad checksum, then reload ----------------
        pulse_start();
        check("t2_cpu_reset_drops", {31'd0, cpu_reset}, 32'd0);
        check("t2_done_drops",      {31'd0, load_done}, 32'd0);
        send_two_word_image(8'h00);
        check("t2_load_error", {31'd0, load_error}, 32'd1);
        check("t2_cpu_reset",  {31'd0, cpu_reset},  32'd0);
        check("t2_load_done",  {31'd0, load_done},  32'd0);
        pulse_start();
        check("t2_error_clears", {31'd0, load_error}, 32'd0);
        send_two_word_image(8'h55);
        check("t2_reload_done", {31'd0, load_done}, 32'd1);
        check("t2_reload_data", imem_wdata,         32'h0109_5020);

        // ---------------- oversize count 513 ----------------
        pulse_start();
        we_base = we_count;
        send_byte(8'h02); send_byte(8'h01);
        check("t3_load_error", {31'd0, load_error}, 32'd1);
        check("t3_ready_low",  {31'd0, byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("t3_no_writes",  we_count - we_base,  32'd0);

        // ---------------- empty image ----------------
        pulse_start();
        we_base = we_count;
        send_byte(8'h00); send_byte(8'h00);
        check("t4_in_check_ready", {31'd0, byte_ready}, 32'd1);
        send_byte(8'h00);
        check("t4_empty_done", {31'd0, load_done}, 32'd1);
        check("t4_no_writes",  we_count - we_base, 32'd0);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("t4_empty_bad", {31'd0, load_error}, 32'd1);

        // ---------------- one word with a 7-cycle gap ----------------
        // Payload XOR: AA^BB^CC^DD = 0x00.
        pulse_start();
        we_base = we_count;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB);
        repeat (3) @(negedge clk);
        pulse_start();                 // ignored while in DATA
        repeat (3) @(negedge clk);
        check("t5_gap_no_we", we_count - we_base, 32'd0);
        check("t5_gap_ready", {31'd0, byte_ready}, 32'd1);
        send_byte(8'hCC);
        check("t5_no_early_we", {31'd0, imem_we}, 32'd0);
        send_byte(8'hDD);
        check("t5_we",   {31'd0, imem_we}, 32'd1);
        check("t5_addr", imem_address,     32'h0040_0000);
        check("t5_data", imem_wdata,       32'hAABB_CCDD);
        send_byte(8'h00);
        check("t5_done",     {31'd0, load_done}, 32'd1);
        check("t5_we_count", we_count - we_base, 32'd1);

        // ---------------- asynchronous reset mid-DATA ----------------
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34);
        #2;
        reset = 1'b0;                  // between clock edges
        #1;
        check("t6_rst_ready",   {31'd0, byte_ready}, 32'd0);
        check("t6_rst_we",      {31'd0, imem_we},    32'd0);
        check("t6_rst_addr",    imem_address,        32'd0);
        check("t6_rst_data",    imem_wdata,          32'd0);
        check("t6_rst_cpu",     {31'd0, cpu_reset},  32'd0);
        check("t6_rst_done",    {31'd0, load_done},  32'd0);
        check("t6_rst_error",   {31'd0, load_error}, 32'd0);
        @(negedge clk);
        reset      = 1'b1;
        byte_in    = 8'hFF;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_ready", {31'd0, byte_ready}, 32'd0);
        byte_valid = 1'b0;
        // Payload XOR: 12^34^56^78 = 0x08.
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check("t6_reload_addr", imem_address, 32'h0040_0000);
        check("t6_reload_data", imem_wdata,   32'h1234_5678);
        send_byte(8'h08);
        check("t6_reload_done", {31'd0, load_done}, 32'd1);
        check("t6_reload_cpu",  {31'd0, cpu_reset}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
